// File: rtl/ref_buf_axi_wr_arbiter.sv
// ---------------------------------------------------------------------------
// ref_buf_axi_wr_arbiter
//
// Purpose:
//   Shares one AXI write port to DDR between two write masters:
//     requester 0 - reference-buffer (DPB pixel) writeback
//     requester 1 - collocated-MV writeback
//   Arbitration is round-robin at burst granularity. A grant covers the AW
//   handshake and every W beat up to and including wlast. Requester 0 wins
//   the first contended grant after reset.
//
// Optional feature (compile-time macro REF_BUF_WR_ARB_BRESP_ROUTE_EN):
//   defined   - a FIFO of requester IDs tracks bursts awaiting a B response.
//               Responses are routed to the issuing requester in order, and
//               new grants are withheld while the FIFO is full.
//   undefined - no tracking; m_bready is tied high, sN_bvalid/sN_bresp are 0,
//               and grants are never blocked.
//
// Handshake rule: a transfer happens on a rising clk edge where valid and
// ready are both high. An AW request must hold awvalid/addr/len stable until
// it is accepted; W beats are passed through unchanged, and the requester's
// wlast marks the end of the burst (beats are not counted here).
//
// Ports:
//   clk, reset_n                 clock, asynchronous active-low reset
//   sN_aw{valid,addr,len}        requester N address request (N = 0, 1)
//   sN_awready                   requester N address accepted
//   sN_w{data,strb,last,valid}   requester N write data
//   sN_wready                    requester N data accepted
//   sN_bvalid, sN_bresp          routed write response to requester N
//   sN_bready                    requester N response ready
//   m_aw{valid,addr,len}/awready shared AW channel to the interconnect
//   m_w{valid,data,strb,last}    shared W channel to the interconnect
//   m_wready                     interconnect data ready
//   m_bvalid, m_bresp, m_bready  shared B channel from the interconnect
//   dbg_state_o                  current arbiter state (IDLE/ADDR/DATA)
// ---------------------------------------------------------------------------
module ref_buf_axi_wr_arbiter #(
    parameter int AXI_ADDR_WDTH = 32,
    parameter int AXI_DATA_WDTH = 512,
    parameter int OUTST_DEPTH   = 4
) (
    input  logic                         clk,
    input  logic                         reset_n,

    input  logic                         s0_awvalid,
    output logic                         s0_awready,
    input  logic [AXI_ADDR_WDTH-1:0]     s0_awaddr,
    input  logic [7:0]                   s0_awlen,
    input  logic [AXI_DATA_WDTH-1:0]     s0_wdata,
    input  logic [AXI_DATA_WDTH/8-1:0]   s0_wstrb,
    input  logic                         s0_wlast,
    input  logic                         s0_wvalid,
    output logic                         s0_wready,
    output logic                         s0_bvalid,
    output logic [1:0]                   s0_bresp,
    input  logic                         s0_bready,

    input  logic                         s1_awvalid,
    output logic                         s1_awready,
    input  logic [AXI_ADDR_WDTH-1:0]     s1_awaddr,
    input  logic [7:0]                   s1_awlen,
    input  logic [AXI_DATA_WDTH-1:0]     s1_wdata,
    input  logic [AXI_DATA_WDTH/8-1:0]   s1_wstrb,
    input  logic                         s1_wlast,
    input  logic                         s1_wvalid,
    output logic                         s1_wready,
    output logic                         s1_bvalid,
    output logic [1:0]                   s1_bresp,
    input  logic                         s1_bready,

    output logic                         m_awvalid,
    output logic [AXI_ADDR_WDTH-1:0]     m_awaddr,
    output logic [7:0]                   m_awlen,
    input  logic                         m_awready,
    output logic                         m_wvalid,
    output logic [AXI_DATA_WDTH-1:0]     m_wdata,
    output logic [AXI_DATA_WDTH/8-1:0]   m_wstrb,
    output logic                         m_wlast,
    input  logic                         m_wready,
    input  logic                         m_bvalid,
    input  logic [1:0]                   m_bresp,
    output logic                         m_bready,

    output logic [1:0]                   dbg_state_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } state_e;

    state_e state_q, state_d;
    logic   grant_q, grant_d;
    logic   last_grant_q, last_grant_d;
    logic   push;
    logic   fifo_full;

    assign dbg_state_o = state_q;

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;   // makes requester 0 the first contended winner
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
        end
    end

    // -----------------------------------------------------------------------
    // Next state and channel muxing
    // -----------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        push         = 1'b0;

        m_awvalid    = 1'b0;
        m_awaddr     = '0;
        m_awlen      = '0;
        m_wvalid     = 1'b0;
        m_wdata      = '0;
        m_wstrb      = '0;
        m_wlast      = 1'b0;
        s0_awready   = 1'b0;
        s1_awready   = 1'b0;
        s0_wready    = 1'b0;
        s1_wready    = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                // The full check uses the registered occupancy, so a response
                // popped in this same cycle does not open a slot yet.
                if ((s0_awvalid || s1_awvalid) && !fifo_full) begin
                    if (s0_awvalid && s1_awvalid) begin
                        grant_d = ~last_grant_q;
                    end else begin
                        grant_d = s1_awvalid;
                    end
                    state_d = ST_ADDR;
                end
            end

            ST_ADDR: begin
                if (grant_q) begin
                    m_awvalid  = s1_awvalid;
                    m_awaddr   = s1_awaddr;
                    m_awlen    = s1_awlen;
                    s1_awready = m_awready;
                end else begin
                    m_awvalid  = s0_awvalid;
                    m_awaddr   = s0_awaddr;
                    m_awlen    = s0_awlen;
                    s0_awready = m_awready;
                end
                if (m_awvalid && m_awready) begin
                    push    = 1'b1;
                    state_d = ST_DATA;
                end
            end

            ST_DATA: begin
                if (grant_q) begin
                    m_wvalid  = s1_wvalid;
                    m_wdata   = s1_wdata;
                    m_wstrb   = s1_wstrb;
                    m_wlast   = s1_wlast;
                    s1_wready = m_wready;
                end else begin
                    m_wvalid  = s0_wvalid;
                    m_wdata   = s0_wdata;
                    m_wstrb   = s0_wstrb;
                    m_wlast   = s0_wlast;
                    s0_wready = m_wready;
                end
                if (m_wvalid && m_wready && m_wlast) begin
                    last_grant_d = grant_q;
                    state_d      = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

`ifdef REF_BUF_WR_ARB_BRESP_ROUTE_EN
    // -----------------------------------------------------------------------
    // Outstanding-burst ID FIFO: one entry per accepted AW, popped on each
    // B handshake. Depth is a power of two so the pointers wrap naturally.
    // -----------------------------------------------------------------------
    localparam int PTR_W = (OUTST_DEPTH > 1) ? $clog2(OUTST_DEPTH) : 1;
    localparam int CNT_W = $clog2(OUTST_DEPTH) + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(OUTST_DEPTH);

    logic [OUTST_DEPTH-1:0] id_fifo_q;
    logic [PTR_W-1:0]       wr_ptr_q;
    logic [PTR_W-1:0]       rd_ptr_q;
    logic [CNT_W-1:0]       cnt_q;
    logic                   fifo_empty;
    logic                   head_id;
    logic                   pop;

    assign fifo_empty = (cnt_q == '0);
    assign fifo_full  = (cnt_q == FULL_CNT);
    assign head_id    = id_fifo_q[rd_ptr_q];

    // A response with nothing outstanding is held off rather than dropped.
    assign m_bready  = !fifo_empty && (head_id ? s1_bready : s0_bready);
    assign s0_bvalid = m_bvalid && !fifo_empty && !head_id;
    assign s1_bvalid = m_bvalid && !fifo_empty &&  head_id;
    assign s0_bresp  = s0_bvalid ? m_bresp : 2'b00;
    assign s1_bresp  = s1_bvalid ? m_bresp : 2'b00;
    assign pop       = m_bvalid && m_bready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            id_fifo_q <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            cnt_q     <= '0;
        end else begin
            if (push) begin
                id_fifo_q[wr_ptr_q] <= grant_q;
                wr_ptr_q            <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            unique case ({push, pop})
                2'b10:   cnt_q <= cnt_q + CNT_W'(1);
                2'b01:   cnt_q <= cnt_q - CNT_W'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // Simulation-only flag for a response arriving with nothing outstanding.
    always @(posedge clk) begin
        if (reset_n && m_bvalid && fifo_empty) begin
            $error("ref_buf_axi_wr_arbiter: m_bvalid with no outstanding burst");
        end
    end
`else
    // Responses are not tracked: accept and discard every B beat.
    assign fifo_full = 1'b0;
    assign m_bready  = 1'b1;
    assign s0_bvalid = 1'b0;
    assign s1_bvalid = 1'b0;
    assign s0_bresp  = 2'b00;
    assign s1_bresp  = 2'b00;

    logic unused_b;
    assign unused_b = ^{push, s0_bready, s1_bready, m_bvalid, m_bresp};
`endif

endmodule
